spi_frame_writer: RTL and testbench
===================================

# spi_frame_writer

Command sequencer between the SPI word receiver and the HUB75 framebuffer write port. It decodes the 16-bit word stream into address, pixel-run, fill and buffer-swap operations. It drives a single-port framebuffer write interface in the spi_clk domain and runs a req/ack buffer-swap handshake with the display scan side.

## Interface
- ADDR_WIDTH, 11, framebuffer address width; depth = 2^ADDR_WIDTH; legal range 1..12
- reset  in  1  asynchronous, active-high
- spi_clk  in  1  clock; all state changes on its rising edge
- word_data  in  16  received word, valid while word_strobe high
- word_strobe  in  1  high for exactly one spi_clk cycle per completed word
- swap_ack  in  1  display-side acknowledge, already synchronised to spi_clk
- fb_addr  out  ADDR_WIDTH  write address, registered
- fb_data  out  16  write pixel, registered
- fb_we  out  1  write enable, one cycle per pixel
- fb_bank  out  1  back buffer currently being written
- swap_req  out  1  buffer-swap request
- busy  out  1  high in FILLING, SWAP_WAIT, SWAP_DONE
- error  out  1  sticky protocol error, cleared only by reset

## Operation
- Command word: bit15=1; opcode = bits14:12; arg = bits11:0. Word 0x8000 is NOP.
- Opcodes:
  - 0 NOP
  - 1 SET_ADDR: addr <= arg[ADDR_WIDTH-1:0]
  - 2 RUN: the next arg words are pixels
  - 3 SWAP
  - 4 FILL: the next word is a colour; write it to arg pixels
  - 5-7: treated as NOP
- States: IDLE, RUN, FILL_COLOUR, FILLING, SWAP_WAIT, SWAP_DONE.
- IDLE:
  - Command words are decoded.
  - A data word (bit15=0) is ignored and sets error.
  - RUN or FILL with arg=0 is a NOP and stays in IDLE.
- RUN: every strobed word (any value, including 0x8000) is a pixel. It is written at addr, then addr increments. After arg pixels, go to IDLE.
- FILL_COLOUR: the next strobed word is latched as the colour, then go to FILLING.
- FILLING: one write per spi_clk cycle, arg writes total, addresses A..A+arg-1. Then go to IDLE with addr = A+arg.
- SWAP_WAIT: swap_req=1 until swap_ack=1. Then swap_req=0, fb_bank toggles, addr <= 0, go to SWAP_DONE.
- SWAP_DONE: wait for swap_ack=0, then go to IDLE.
- Words strobed in FILLING, SWAP_WAIT or SWAP_DONE are dropped. error is set unless the dropped word is 0x8000. The master pads with NOPs to keep spi_clk running.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap from 2^ADDR_WIDTH-1 to 0 is silent.
- The run/fill counter is 12-bit; only the decrement path is used.

## Timing
- Reset values:
  - fb_addr=0, fb_data=0, fb_we=0, fb_bank=0, swap_req=0, busy=0, error=0
  - state IDLE, addr=0
- Reset asserted mid-run, fill or swap aborts immediately. A pending swap is abandoned without a bank toggle.
- RUN pixel strobed at edge t: fb_we=1 with fb_addr/fb_data valid in cycle t+1 only. fb_we=0 otherwise.
- FILL colour strobed at edge t: fb_we=1 in cycles t+1..t+arg. busy=1 in exactly those cycles. busy=0 and state IDLE at t+arg+1.
- A word strobed in the cycle of the last fill write is dropped (FILLING still active).
- SWAP strobed at edge t: swap_req=1 and busy=1 from t+1.
- swap_ack sampled high at edge u: swap_req=0 and fb_bank toggled from u+1.
- swap_ack sampled low at a later edge v: busy=0 and state IDLE from v+1.
- If swap_ack is already high on entry to SWAP_WAIT, the ack is taken at the first edge. A minimum one-cycle req pulse is still required.
- word_strobe coincident with swap_ack in SWAP_WAIT: the ack is processed and the word is dropped under the error rule.
- Latency SET_ADDR to next write address: effective from the next strobe.

## Test plan
- Reset, then SET_ADDR 0x9005 (addr 5), RUN 0xA003, pixels 0x1234, 0x8000, 0x0001 -> three fb_we pulses at addr 5/6/7 with those data; state IDLE; error=0.
- SET_ADDR 0x97FE, RUN 0xA004, pixels 1..4 -> writes at 0x7FE, 0x7FF, 0x000, 0x001 (wrap); next addr 2.
- SET_ADDR 0x9010, FILL 0xC005, colour 0xF800 -> fb_we high 5 consecutive cycles at addr 0x10..0x14, data 0xF800; busy high the same 5 cycles.
- During that fill, strobe a 0x8000 word and then a 0x1111 word -> both dropped; error=0 after the 0x8000 word, error=1 after the 0x1111 word.
- SWAP 0xB000, hold swap_ack low 10 cycles, raise for 3, drop -> swap_req high until the cycle after ack; fb_bank 0->1 and addr=0 once ack is seen; busy low the cycle after ack falls; a subsequent RUN writes from addr 0.
- Assert reset during a RUN of 0xA010 after 4 pixels, with swap_req high in a second run -> all outputs return to reset values and no bank toggle occurs. In IDLE, a data word 0x0042 -> no write, error=1.

Source files
------------

// File: rtl/spi_frame_writer.sv
// spi_frame_writer: decodes the SPI 16-bit word stream into framebuffer
// writes (address set, pixel runs, colour fills) and runs the req/ack
// buffer-swap handshake with the display scan side.
module spi_frame_writer #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic [15:0]           word_data,
  input  logic                  word_strobe,
  input  logic                  swap_ack,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic [15:0]           fb_data,
  output logic                  fb_we,
  output logic                  fb_bank,
  output logic                  swap_req,
  output logic                  busy,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_FILL_COLOUR, S_FILLING, S_SWAP_WAIT, S_SWAP_DONE
  } state_t;

  localparam logic [15:0] NOP_WORD = 16'h8000;
  localparam logic [2:0]  OP_SET_ADDR = 3'd1;
  localparam logic [2:0]  OP_RUN      = 3'd2;
  localparam logic [2:0]  OP_SWAP     = 3'd3;
  localparam logic [2:0]  OP_FILL     = 3'd4;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [11:0]           cnt_q, cnt_d;
  logic [15:0]           colour_q, colour_d;
  logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
  logic [15:0]           fb_data_q, fb_data_d;
  logic                  fb_we_q, fb_we_d;
  logic                  fb_bank_q, fb_bank_d;
  logic                  swap_req_q, swap_req_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;

  logic        is_cmd;
  logic [2:0]  opcode;
  logic [11:0] arg;
  logic        drop_err;

  assign is_cmd   = word_data[15];
  assign opcode   = word_data[14:12];
  assign arg      = word_data[11:0];
  // A word arriving while the sequencer cannot accept it is a protocol error,
  // except the NOP padding the master uses to keep the clock running.
  assign drop_err = word_strobe && (word_data != NOP_WORD);

  // Next-state, write-port and handshake decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    colour_d  = colour_q;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    fb_we_d   = 1'b0;
    fb_bank_d = fb_bank_q;
    error_d   = error_q;

    case (state_q)
      S_IDLE: begin
        if (word_strobe) begin
          if (!is_cmd) begin
            error_d = 1'b1;
          end else begin
            case (opcode)
              OP_SET_ADDR: addr_d = arg[ADDR_WIDTH-1:0];
              OP_RUN: if (arg != 12'd0) begin
                cnt_d   = arg;
                state_d = S_RUN;
              end
              OP_SWAP: state_d = S_SWAP_WAIT;
              OP_FILL: if (arg != 12'd0) begin
                cnt_d   = arg;
                state_d = S_FILL_COLOUR;
              end
              default: ;
            endcase
          end
        end
      end
      S_RUN: begin
        // Every strobed word is a pixel here, command-looking or not.
        if (word_strobe) begin
          fb_we_d   = 1'b1;
          fb_addr_d = addr_q;
          fb_data_d = word_data;
          addr_d    = addr_q + ADDR_WIDTH'(1);
          cnt_d     = cnt_q - 12'd1;
          if (cnt_q == 12'd1) state_d = S_IDLE;
        end
      end
      S_FILL_COLOUR: begin
        // The first fill write goes out alongside the colour latch so the
        // write burst starts the cycle after the colour word.
        if (word_strobe) begin
          colour_d  = word_data;
          fb_we_d   = 1'b1;
          fb_addr_d = addr_q;
          fb_data_d = word_data;
          addr_d    = addr_q + ADDR_WIDTH'(1);
          cnt_d     = cnt_q - 12'd1;
          state_d   = S_FILLING;
        end
      end
      S_FILLING: begin
        if (drop_err) error_d = 1'b1;
        if (cnt_q != 12'd0) begin
          fb_we_d   = 1'b1;
          fb_addr_d = addr_q;
          fb_data_d = colour_q;
          addr_d    = addr_q + ADDR_WIDTH'(1);
          cnt_d     = cnt_q - 12'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SWAP_WAIT: begin
        if (drop_err) error_d = 1'b1;
        if (swap_ack) begin
          fb_bank_d = ~fb_bank_q;
          addr_d    = '0;
          state_d   = S_SWAP_DONE;
        end
      end
      S_SWAP_DONE: begin
        if (drop_err) error_d = 1'b1;
        if (!swap_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    swap_req_d = (state_d == S_SWAP_WAIT);
    busy_d     = (state_d == S_FILLING) || (state_d == S_SWAP_WAIT) ||
                 (state_d == S_SWAP_DONE);
  end

  // State and registered outputs; reset aborts any run, fill or pending swap.
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      colour_q   <= '0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      fb_we_q    <= 1'b0;
      fb_bank_q  <= 1'b0;
      swap_req_q <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      colour_q   <= colour_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      fb_we_q    <= fb_we_d;
      fb_bank_q  <= fb_bank_d;
      swap_req_q <= swap_req_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  assign fb_addr  = fb_addr_q;
  assign fb_data  = fb_data_q;
  assign fb_we    = fb_we_q;
  assign fb_bank  = fb_bank_q;
  assign swap_req = swap_req_q;
  assign busy     = busy_q;
  assign error    = error_q;

endmodule

// File: tb/tb_spi_frame_writer.sv
// Bench for spi_frame_writer: expected writes are queued as stimulus is
// driven and checked by a monitor whenever fb_we is seen.
module tb_spi_frame_writer;

  localparam int AW = 11;

  logic          reset, spi_clk;
  logic [15:0]   word_data;
  logic          word_strobe, swap_ack;
  logic [AW-1:0] fb_addr;
  logic [15:0]   fb_data;
  logic          fb_we, fb_bank, swap_req, busy, error;

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass = 0;
  int  n_total = 0;

  spi_frame_writer #(.ADDR_WIDTH(AW)) dut (
    .reset(reset), .spi_clk(spi_clk), .word_data(word_data),
    .word_strobe(word_strobe), .swap_ack(swap_ack), .fb_addr(fb_addr),
    .fb_data(fb_data), .fb_we(fb_we), .fb_bank(fb_bank), .swap_req(swap_req),
    .busy(busy), .error(error)
  );

  initial spi_clk = 1'b0;
  always #5 spi_clk = ~spi_clk;

  // Scoreboard: every write the DUT issues must match the oldest expectation.
  always @(negedge spi_clk) begin
    if (fb_we) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write addr=%h data=%h", fb_addr, fb_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (fb_addr !== e.a || fb_data !== e.d)
          $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                   fb_addr, fb_data, e.a, e.d);
        else n_pass++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge spi_clk); #1;
    end
  endtask

  task automatic send(input logic [15:0] w);
    word_data = w; word_strobe = 1'b1;
    @(posedge spi_clk); #1;
    word_strobe = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic check_drained(input string name);
    n_total++;
    if (exp_q.size() !== 0)
      $display("FAIL %s pending_writes=%0d expected 0", name, exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic check_zero(input string name);
    logic [AW+21:0] v;
    v = {fb_addr, fb_data, fb_we, fb_bank, swap_req, busy, error};
    n_total++;
    if (v !== '0) $display("FAIL %s outputs=%h expected 0", name, v);
    else n_pass++;
  endtask

  task automatic test_reset();
    word_data = '0; word_strobe = 1'b0; swap_ack = 1'b0; reset = 1'b1;
    #12;
    check_zero("reset_values");
    @(posedge spi_clk); #1;
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_run();
    send(16'h9005);
    send(16'hA003);
    push(11'd5, 16'h1234); send(16'h1234);
    push(11'd6, 16'h8000); send(16'h8000);
    push(11'd7, 16'h0001); send(16'h0001);
    tick(2);
    // Back in IDLE, a NOP must not produce a write.
    send(16'h8000);
    tick(2);
    check_drained("run_writes");
    n_total++;
    if (error !== 1'b0 || busy !== 1'b0)
      $display("FAIL run_flags error=%b busy=%b expected 0 0", error, busy);
    else n_pass++;
  endtask

  task automatic test_wrap();
    send(16'h97FE);
    send(16'hA004);
    for (int i = 1; i <= 4; i++) begin
      push(AW'(11'h7FE + i - 1), 16'(i));
      send(16'(i));
    end
    send(16'hA001);
    push(11'd2, 16'h00AA); send(16'h00AA);
    tick(2);
    check_drained("wrap_writes");
  endtask

  task automatic test_fill();
    int bad_busy;
    bad_busy = 0;
    send(16'h9010);
    send(16'hC005);
    for (int i = 0; i < 5; i++) push(AW'(16 + i), 16'hF800);
    send(16'hF800);
    for (int i = 0; i < 5; i++) begin
      if (busy !== 1'b1 || fb_we !== 1'b1) bad_busy++;
      if (i == 1) begin word_data = 16'h8000; word_strobe = 1'b1; end
      else if (i == 3) begin word_data = 16'h1111; word_strobe = 1'b1; end
      else word_strobe = 1'b0;
      @(posedge spi_clk); #1;
      word_strobe = 1'b0;
      if (i == 2) begin
        n_total++;
        if (error !== 1'b0) $display("FAIL fill_nop_drop error=%b expected 0", error);
        else n_pass++;
      end
      if (i == 4) begin
        n_total++;
        if (error !== 1'b1) $display("FAIL fill_data_drop error=%b expected 1", error);
        else n_pass++;
      end
    end
    n_total++;
    if (bad_busy != 0) $display("FAIL fill_busy_we bad_cycles=%0d expected 0", bad_busy);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || fb_we !== 1'b0)
      $display("FAIL fill_end busy=%b we=%b expected 0 0", busy, fb_we);
    else n_pass++;
    // Fill leaves the address just past the last write.
    send(16'hA001);
    push(11'h015, 16'h0BEE); send(16'h0BEE);
    tick(2);
    check_drained("fill_writes");
  endtask

  task automatic test_swap();
    int bad;
    bad = 0;
    send(16'hB000);
    for (int i = 0; i < 10; i++) begin
      if (swap_req !== 1'b1 || busy !== 1'b1 || fb_bank !== 1'b0) bad++;
      tick(1);
    end
    n_total++;
    if (bad != 0) $display("FAIL swap_wait bad_cycles=%0d expected 0", bad);
    else n_pass++;
    swap_ack = 1'b1;
    tick(1);
    n_total++;
    if (swap_req !== 1'b0 || fb_bank !== 1'b1 || busy !== 1'b1)
      $display("FAIL swap_ack req=%b bank=%b busy=%b expected 0 1 1",
               swap_req, fb_bank, busy);
    else n_pass++;
    tick(2);
    swap_ack = 1'b0;
    tick(1);
    n_total++;
    if (busy !== 1'b0) $display("FAIL swap_done busy=%b expected 0", busy);
    else n_pass++;
    send(16'hA002);
    push(11'd0, 16'h0123); send(16'h0123);
    push(11'd1, 16'h0456); send(16'h0456);
    tick(2);
    check_drained("swap_addr0");
  endtask

  task automatic test_ack_early();
    swap_ack = 1'b1;
    send(16'hB000);
    n_total++;
    if (swap_req !== 1'b1 || fb_bank !== 1'b1)
      $display("FAIL early_ack_pulse req=%b bank=%b expected 1 1", swap_req, fb_bank);
    else n_pass++;
    tick(1);
    n_total++;
    if (swap_req !== 1'b0 || fb_bank !== 1'b0)
      $display("FAIL early_ack_toggle req=%b bank=%b expected 0 0", swap_req, fb_bank);
    else n_pass++;
    swap_ack = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_abort();
    do_reset();
    send(16'h9020);
    send(16'hA010);
    for (int i = 0; i < 4; i++) begin
      push(AW'(32 + i), 16'h0A00 + 16'(i));
      send(16'h0A00 + 16'(i));
    end
    tick(1);
    reset = 1'b1; #1;
    check_zero("reset_mid_run");
    check_drained("reset_run_writes");
    tick(1); reset = 1'b0; tick(1);
    send(16'hB000);
    n_total++;
    if (swap_req !== 1'b1) $display("FAIL swap_before_reset req=%b expected 1", swap_req);
    else n_pass++;
    reset = 1'b1; #1;
    check_zero("reset_mid_swap");
    tick(1); reset = 1'b0;
    swap_ack = 1'b1;
    tick(3);
    n_total++;
    if (fb_bank !== 1'b0 || swap_req !== 1'b0)
      $display("FAIL swap_abandoned bank=%b req=%b expected 0 0", fb_bank, swap_req);
    else n_pass++;
    swap_ack = 1'b0;
    tick(1);
    send(16'h0042);
    tick(2);
    n_total++;
    if (error !== 1'b1 || fb_we !== 1'b0)
      $display("FAIL idle_data error=%b we=%b expected 1 0", error, fb_we);
    else n_pass++;
    check_drained("idle_data_nowrite");
  endtask

  initial begin
    test_reset();
    test_run();
    test_wrap();
    test_fill();
    test_swap();
    test_ack_early();
    test_reset_abort();
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
